// File: rtl/relu_tile_streamer_pkg.sv
// Shared constants for the ReLU tile streamer: word/tile geometry and fp32 sign handling.
package relu_tile_streamer_pkg;

    localparam int W          = 32;
    localparam int N          = 3;
    localparam int TILE_WORDS = N * N;
    localparam int FP_SIGN_BIT = 31;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp32_relu.sv
// Combinational fp32 ReLU: any word with the sign bit set (including -0 and negative NaN) becomes +0.
module fp32_relu
    import relu_tile_streamer_pkg::*;
(
    input  logic         relu_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Clamp sign-set words to +0 when enabled; otherwise pass through untouched.
    always_comb begin
        if (relu_en && din[FP_SIGN_BIT]) begin
            dout = FP_ZERO;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/relu_tile_streamer.sv
// Captures 3x3 fp32 result tiles into a ping-pong buffer pair, optionally applies ReLU,
// and streams the words one per cycle over a valid/ready handshake.
module relu_tile_streamer
    import relu_tile_streamer_pkg::*;
#(
    parameter int W = relu_tile_streamer_pkg::W,
    parameter int N = relu_tile_streamer_pkg::N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W*N*N-1:0] conv_out_final,
    input  logic             conv_valid,
    output logic             conv_ready,
    input  logic             relu_en,
    output logic [W-1:0]     out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_row_end,
    output logic             out_last,
    output logic [15:0]      tile_count
);

    localparam int TILE  = N * N;
    localparam int IDX_W = $clog2(TILE);

    logic [W-1:0]     tile_buf_r [2][TILE];
    logic [W-1:0]     relu_word_s [TILE];
    logic             wr_sel_r;
    logic             rd_sel_r;
    logic [1:0]       occ_r;
    logic [IDX_W-1:0] idx_r;
    logic [15:0]      tile_count_r;
    logic             load_s;
    logic             xfer_s;
    logic             xfer_last_s;

    for (genvar k = 0; k < TILE; k++) begin : g_relu
        fp32_relu u_relu (
            .relu_en (relu_en),
            .din     (conv_out_final[W*k +: W]),
            .dout    (relu_word_s[k])
        );
    end

    // Handshake and output word decode from the current buffer/index state.
    always_comb begin
        conv_ready  = !reset && (occ_r < 2'd2);
        out_valid   = (occ_r != 2'd0);
        load_s      = conv_valid && conv_ready;
        xfer_s      = out_valid && out_ready;
        if (out_valid) begin
            out_pixel = tile_buf_r[rd_sel_r][idx_r];
        end else begin
            out_pixel = {W{1'b0}};
        end
        out_row_end = out_valid && ((int'(idx_r) % N) == (N - 1));
        out_last    = out_valid && (idx_r == IDX_W'(TILE - 1));
        xfer_last_s = xfer_s && out_last;
    end

    assign tile_count = tile_count_r;

    // Buffer capture, read pointer advance and occupancy bookkeeping; buffers are masked by occ, not cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_r        <= 2'd0;
            idx_r        <= '0;
            wr_sel_r     <= 1'b0;
            rd_sel_r     <= 1'b0;
            tile_count_r <= 16'd0;
        end else begin
            if (load_s) begin
                for (int k = 0; k < TILE; k++) begin
                    tile_buf_r[wr_sel_r][k] <= relu_word_s[k];
                end
                wr_sel_r <= ~wr_sel_r;
            end else begin
                wr_sel_r <= wr_sel_r;
            end
            if (xfer_last_s) begin
                idx_r        <= '0;
                rd_sel_r     <= ~rd_sel_r;
                tile_count_r <= tile_count_r + 16'd1;
            end else if (xfer_s) begin
                idx_r        <= idx_r + IDX_W'(1);
            end else begin
                idx_r        <= idx_r;
            end
            // A load coinciding with a tile's final word leaves occupancy unchanged.
            case ({load_s, xfer_last_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_tile_streamer.sv
// Self-checking bench: table vectors, directed handshake corner cases and a random run against a word-queue model.
module tb_relu_tile_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic [287:0] conv_out_final;
    logic         conv_valid;
    logic         conv_ready;
    logic         relu_en;
    logic [31:0]  out_pixel;
    logic         out_valid;
    logic         out_ready;
    logic         out_row_end;
    logic         out_last;
    logic [15:0]  tile_count;

    relu_tile_streamer dut (
        .clk            (clk),
        .reset          (reset),
        .conv_out_final (conv_out_final),
        .conv_valid     (conv_valid),
        .conv_ready     (conv_ready),
        .relu_en        (relu_en),
        .out_pixel      (out_pixel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row_end    (out_row_end),
        .out_last       (out_last),
        .tile_count     (tile_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          k;
    } ent_t;

    typedef struct packed {
        logic [287:0] tile;
        logic         re;
        logic [287:0] exp_tile;
    } vec_t;

    ent_t        mq[$];
    logic [15:0] m_count;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          model_chk = 1'b0;

    logic        o_ready, o_valid, o_row, o_last;
    logic [31:0] o_pix;
    logic [15:0] o_cnt;

    function automatic logic [31:0] ref_relu(input logic [31:0] w, input logic en);
        return (en && w[31]) ? 32'h0000_0000 : w;
    endfunction

    function automatic logic [287:0] pack9(input logic [31:0] a [9]);
        logic [287:0] t = '0;
        for (int k = 0; k < 9; k++) t[32*k +: 32] = a[k];
        return t;
    endfunction

    function automatic logic [31:0] word_of(input logic [287:0] t, input int k);
        return t[32*k +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, sample, compare against model, then advance the model across the edge.
    task automatic cycle(input logic rst, input logic cv, input logic re, input logic ordy,
                         input logic [287:0] tile);
        logic        e_ready, e_valid, e_row, e_last;
        logic [31:0] e_pix;
        int          held;
        @(negedge clk);
        reset = rst; conv_valid = cv; relu_en = re; out_ready = ordy; conv_out_final = tile;
        #1;
        held    = (mq.size() + 8) / 9;
        e_ready = !rst && (held < 2);
        e_valid = (mq.size() != 0);
        e_pix   = 32'h0; e_row = 1'b0; e_last = 1'b0;
        if (e_valid) begin
            e_pix  = mq[0].w;
            e_row  = (mq[0].k % 3) == 2;
            e_last = (mq[0].k == 8);
        end
        o_ready = conv_ready; o_valid = out_valid; o_pix = out_pixel;
        o_row = out_row_end; o_last = out_last; o_cnt = tile_count;
        if (model_chk) begin
            chk("m_conv_ready", {31'd0, o_ready}, {31'd0, e_ready});
            chk("m_out_valid",  {31'd0, o_valid}, {31'd0, e_valid});
            chk("m_out_pixel",  o_pix, e_pix);
            chk("m_row_end",    {31'd0, o_row}, {31'd0, e_row});
            chk("m_last",       {31'd0, o_last}, {31'd0, e_last});
            chk("m_tile_count", {16'd0, o_cnt}, {16'd0, m_count});
        end
        if (rst) begin
            mq.delete();
            m_count = 16'd0;
        end else begin
            if (e_valid && ordy) begin
                if (mq[0].k == 8) m_count = m_count + 16'd1;
                void'(mq.pop_front());
            end
            if (cv && e_ready) begin
                for (int k = 0; k < 9; k++) mq.push_back('{w: ref_relu(word_of(tile, k), re), k: k});
            end
        end
    endtask

    vec_t        vecs [3];
    logic [31:0] a [9];
    logic [31:0] b [9];
    logic [31:0] got_q[$];
    logic [287:0] tA, tB, tC, tD, tE;

    initial begin
        reset = 1'b1; conv_valid = 1'b0; relu_en = 1'b0; out_ready = 1'b0; conv_out_final = '0;
        m_count = 16'd0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        model_chk = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_conv_ready_low", {31'd0, o_ready}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_out_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_out_pixel", o_pix, 32'h0);
        chk("rst_row_end",   {31'd0, o_row}, 32'd0);
        chk("rst_last",      {31'd0, o_last}, 32'd0);
        chk("rst_tile_count", {16'd0, o_cnt}, 32'd0);
        chk("rst_conv_ready_high", {31'd0, o_ready}, 32'd1);

        // Table vectors
        for (int k = 0; k < 9; k++) a[k] = 32'h3F00_0000 + 32'h0010_0000 * k;
        vecs[0].tile = pack9(a); vecs[0].re = 1'b0; vecs[0].exp_tile = pack9(a);
        a = '{32'hBF80_0000, 32'h8000_0000, 32'hFFC0_0000, 32'h7FC0_0000, 32'h3F70_0000,
              32'h0000_0001, 32'h8000_0001, 32'hFF80_0000, 32'h7F80_0000};
        b = '{32'h0, 32'h0, 32'h0, 32'h7FC0_0000, 32'h3F70_0000,
              32'h0000_0001, 32'h0, 32'h0, 32'h7F80_0000};
        vecs[1].tile = pack9(a); vecs[1].re = 1'b1; vecs[1].exp_tile = pack9(b);
        vecs[2].tile = pack9(a); vecs[2].re = 1'b0; vecs[2].exp_tile = pack9(a);
        for (int v = 0; v < 3; v++) begin
            cycle(1'b0, 1'b1, vecs[v].re, 1'b1, vecs[v].tile);
            for (int k = 0; k < 9; k++) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
                chk($sformatf("vec%0d_w%0d", v, k), o_pix, word_of(vecs[v].exp_tile, k));
                chk($sformatf("vec%0d_row%0d", v, k), {31'd0, o_row}, {31'd0, (k % 3) == 2});
                chk($sformatf("vec%0d_last%0d", v, k), {31'd0, o_last}, {31'd0, k == 8});
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
            chk($sformatf("vec%0d_tile_count", v), {16'd0, o_cnt}, v + 1);
            chk($sformatf("vec%0d_drained", v), {31'd0, o_valid}, 32'd0);
        end

        // Backpressure with out_ready toggling 1010...
        for (int k = 0; k < 9; k++) a[k] = 32'h4000_0000 + k;
        tA = pack9(a);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tA);
        got_q.delete();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 1'b0, (i % 2) == 0, '0);
            if (o_valid && out_ready) got_q.push_back(o_pix);
        end
        chk("bp_xfer_count", got_q.size(), 32'd9);
        for (int k = 0; k < 9 && k < got_q.size(); k++)
            chk($sformatf("bp_word%0d", k), got_q[k], a[k]);

        // Ping-pong: three tiles offered with out_ready low, then drain
        for (int k = 0; k < 9; k++) a[k] = 32'h1000_0000 + k;
        tA = pack9(a);
        for (int k = 0; k < 9; k++) a[k] = 32'h2000_0000 + k;
        tB = pack9(a);
        for (int k = 0; k < 9; k++) a[k] = 32'h3000_0000 + k;
        tC = pack9(a);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tA);
        chk("pp_first_ready", {31'd0, o_ready}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tB);
        chk("pp_second_ready", {31'd0, o_ready}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tC);
        chk("pp_third_blocked", {31'd0, o_ready}, 32'd0);
        begin
            int xfers = 0, bubbles = 0, acc_at = -1;
            got_q.delete();
            for (int i = 0; i < 40 && xfers < 27; i++) begin
                cycle(1'b0, acc_at < 0, 1'b0, 1'b1, tC);
                if (acc_at < 0 && o_ready) acc_at = i;
                if (o_valid) begin
                    xfers++;
                    got_q.push_back(o_pix);
                end else begin
                    bubbles++;
                end
            end
            chk("pp_xfers", xfers, 32'd27);
            chk("pp_bubbles", bubbles, 32'd0);
            chk("pp_third_accept_cycle", acc_at, 32'd9);
            if (got_q.size() == 27) begin
                chk("pp_w0", got_q[0], 32'h1000_0000);
                chk("pp_w9", got_q[9], 32'h2000_0000);
                chk("pp_w26", got_q[26], 32'h3000_0008);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("pp_tile_count", {16'd0, o_cnt}, 32'd7);

        // Load coinciding with last-word transfer at occ=1
        for (int k = 0; k < 9; k++) a[k] = 32'h5000_0000 + k;
        tD = pack9(a);
        for (int k = 0; k < 9; k++) a[k] = 32'h6000_0000 + k;
        tE = pack9(a);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, tD);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, tE);
        chk("sim_last", {31'd0, o_last}, 32'd1);
        chk("sim_ready", {31'd0, o_ready}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("sim_next_valid", {31'd0, o_valid}, 32'd1);
        chk("sim_next_w0", o_pix, 32'h6000_0000);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("sim_tile_count", {16'd0, o_cnt}, 32'd9);

        // Reset mid-stream at word 4 with two tiles held
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tA);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, tB);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("mid_word4", o_pix, 32'h1000_0003);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        chk("mid_rst_ready_low", {31'd0, o_ready}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("mid_out_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_out_pixel", o_pix, 32'h0);
        chk("mid_tile_count", {16'd0, o_cnt}, 32'd0);
        chk("mid_ready_high", {31'd0, o_ready}, 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [287:0] t;
            for (int k = 0; k < 9; k++) begin
                case ($urandom_range(0, 3))
                    0:       t[32*k +: 32] = 32'h8000_0000 | $urandom;
                    1:       t[32*k +: 32] = 32'h7FFF_FFFF & $urandom;
                    default: t[32*k +: 32] = $urandom;
                endcase
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, t);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
